// File: rtl/extmem_arb_pkg.sv
// extmem_arb_pkg: types and helpers shared by the external-memory arbiter
// and the buffer-port arbiters.
//   arb_state_e  : arbiter FSM states (IDLE, ARB, BURST)
//   rr_pick_t    : result of a round-robin pick (found flag + index)
//   rr_pick()    : first asserted request scanning upward from a pointer,
//                  wrapping modulo the number of live requesters
package extmem_arb_pkg;

  localparam int EXTMEM_ARB_MAX_REQ = 8;
  localparam int EXTMEM_ARB_IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_BURST = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                        found;
    logic [EXTMEM_ARB_IDX_W-1:0] idx;
  } rr_pick_t;

  // Requests above n_req are ignored; n_req is at least 2.
  function automatic rr_pick_t rr_pick(
    input logic [EXTMEM_ARB_MAX_REQ-1:0] req,
    input logic [EXTMEM_ARB_IDX_W-1:0]   ptr,
    input int unsigned                   n_req
  );
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < EXTMEM_ARB_MAX_REQ; k++) begin
      j = (32'(ptr) + k) % n_req;
      if ((k < n_req) && req[j[2:0]] && !res.found) begin
        res.found = 1'b1;
        res.idx   = j[EXTMEM_ARB_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/extmem_arbiter_if.sv
// extmem_arbiter_if: requester-side and memory-side signals of the
// external-memory arbiter.
//   req/we/last [N_REQ]     requester transfer request, direction, burst end
//   addr/wdata  [N_REQ][..] requester word address and write data
//   gnt/rvalid  [N_REQ]     one-hot grant and read-return strobe
//   rdata, busy, owner      returned read data, port lock, current owner
//   mem_*                   external memory strobes, addresses and data
// Modports: slave = arbiter, master = requesters plus memory model.
interface extmem_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0]             we;
  logic [N_REQ-1:0]             last;
  logic [N_REQ-1:0][ADDR_W-1:0] addr;
  logic [N_REQ-1:0][DATA_W-1:0] wdata;
  logic [N_REQ-1:0]             gnt;
  logic [N_REQ-1:0]             rvalid;
  logic [DATA_W-1:0]            rdata;
  logic                         busy;
  logic [IDX_W-1:0]             owner;
  logic                         mem_we;
  logic                         mem_re;
  logic [ADDR_W-1:0]            mem_wr_addr;
  logic [ADDR_W-1:0]            mem_rd_addr;
  logic [DATA_W-1:0]            mem_wr_data;
  logic [DATA_W-1:0]            mem_rd_data;

  modport slave (
    input  req, we, last, addr, wdata, mem_rd_data,
    output gnt, rvalid, rdata, busy, owner,
           mem_we, mem_re, mem_wr_addr, mem_rd_addr, mem_wr_data
  );

  modport master (
    output req, we, last, addr, wdata, mem_rd_data,
    input  gnt, rvalid, rdata, busy, owner,
           mem_we, mem_re, mem_wr_addr, mem_rd_addr, mem_wr_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   i_req   [N_REQ]  request vector
//   i_ptr   [IDX_W]  index with highest priority this round
//   o_idx   [IDX_W]  first asserted request at or above i_ptr (wrapping)
//   o_found          any request asserted
module rr_arbiter
  import extmem_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  logic [EXTMEM_ARB_MAX_REQ-1:0] w_req;
  rr_pick_t                      w_pick;

  always_comb begin
    w_req            = '0;
    w_req[N_REQ-1:0] = i_req;
    w_pick           = rr_pick(w_req, EXTMEM_ARB_IDX_W'(i_ptr), N_REQ);
    o_idx            = w_pick.idx[IDX_W-1:0];
    o_found          = w_pick.found;
  end

endmodule

// File: rtl/extmem_arbiter.sv
// extmem_arbiter: shares the single external-memory port between N_REQ
// requesters. A requester owns the port for one burst; bursts are granted
// round-robin. Reads return one cycle later on rvalid of the issuing
// requester.
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      extmem_arbiter_if.slave (requester handshake + memory port)
module extmem_arbiter
  import extmem_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  extmem_arbiter_if.slave   bus
);

  localparam int               IDX_W    = $clog2(N_REQ);
  localparam int               CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_tag;
  logic             r_tag_vld;
  logic [CNT_W-1:0] r_burst_cnt;

  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_found;
  logic             w_own_req;
  logic             w_xfer;
  logic             w_wr_xfer;
  logic             w_rd_xfer;
  logic             w_hit_max;
  logic             w_release;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req   (bus.req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  always_comb begin
    w_own_req = bus.req[r_owner];
    w_xfer    = (r_state == ST_BURST) && w_own_req;
    w_wr_xfer = w_xfer && bus.we[r_owner];
    w_rd_xfer = w_xfer && !bus.we[r_owner];
    // The transfer in flight is the one that brings the count to the limit.
    w_hit_max = (r_burst_cnt == (CNT_MAX - CNT_W'(1)));
    // A dropped request releases as well; otherwise this cycle is a transfer.
    w_release = (r_state == ST_BURST) &&
                (!w_own_req || bus.last[r_owner] || w_hit_max);

    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (|bus.req) w_state_nxt = ST_ARB;
      ST_ARB:   w_state_nxt = w_pick_found ? ST_BURST : ST_IDLE;
      ST_BURST: if (w_release) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase

    bus.gnt = '0;
    if (r_state == ST_BURST) bus.gnt[r_owner] = w_own_req;

    bus.mem_we      = w_wr_xfer;
    bus.mem_re      = w_rd_xfer;
    bus.mem_wr_addr = w_wr_xfer ? bus.addr[r_owner]  : '0;
    bus.mem_wr_data = w_wr_xfer ? bus.wdata[r_owner] : '0;
    bus.mem_rd_addr = w_rd_xfer ? bus.addr[r_owner]  : '0;

    // Read return is tied to the tag only, so it completes in any state.
    bus.rvalid = '0;
    if (r_tag_vld) bus.rvalid[r_tag] = 1'b1;
    bus.rdata = r_tag_vld ? bus.mem_rd_data : '0;

    bus.busy  = (r_state != ST_IDLE);
    bus.owner = r_owner;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_tag       <= '0;
      r_tag_vld   <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tag_vld <= w_rd_xfer;
      r_tag     <= r_owner;
      if ((r_state == ST_ARB) && w_pick_found) begin
        r_owner     <= w_pick_idx;
        r_burst_cnt <= '0;
      end else if (w_xfer && (r_burst_cnt != CNT_MAX)) begin
        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
      end
      if (w_release) r_rr_ptr <= (r_owner == IDX_LAST) ? '0 : r_owner + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_extmem_arbiter.sv
// Bench for extmem_arbiter: directed scenarios pinned by literal
// expectations plus a randomized run, all compared every cycle against a
// lock-owner / pending-read model of the port.
module tb_extmem_arbiter;

  localparam int N    = 3;
  localparam int AW   = 32;
  localparam int DW   = 16;
  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  extmem_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  extmem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // Port model: who holds the lock (-1 none), whether an arbitration
  // cycle is pending, next-in-line pointer, words moved, last owner,
  // and the requester waiting for read data (-1 none).
  int m_lock, m_ptr, m_cnt, m_owner, m_tag;
  bit m_arb;
  logic [DW-1:0] m_rdata;

  // Requester scripts.
  bit            q_act[N];
  bit            q_we[N];
  bit            q_repeat[N];
  int            q_delay[N];
  int            q_len[N];
  int            q_idx[N];
  int            q_drop[N];
  int            q_gap[N];
  logic [AW-1:0] q_base[N];
  bit            rand_mode = 0;

  // Observations of the DUT for the directed literals.
  int cyc;
  int seg_owner[$];
  int seg_start[$];
  int seg_len[$];
  bit prev_dut_x;
  bit busy_hist[64];
  int rv1_cnt;
  logic [AW-1:0] first_wr_addr;
  bit seen_wr;
  bit last_exp_re;

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return (a[DW-1:0] ^ 16'h5A3C) + {a[23:16], a[31:24]};
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.req[i]   = q_act[i] && (q_delay[i] == 0);
      bus.we[i]    = q_we[i];
      bus.addr[i]  = q_base[i] + AW'(q_idx[i]);
      bus.wdata[i] = q_base[i][DW-1:0] + DW'(q_idx[i] * 3) + DW'(i << 12);
      bus.last[i]  = (q_idx[i] == q_len[i] - 1);
    end
  endtask

  task automatic clear_req();
    for (int i = 0; i < N; i++) begin
      q_act[i] = 0; q_we[i] = 0; q_repeat[i] = 0; q_delay[i] = 0;
      q_len[i] = 1; q_idx[i] = 0; q_drop[i] = -1; q_gap[i] = 0; q_base[i] = '0;
    end
  endtask

  task automatic start(input int i, input int len, input bit w, input logic [AW-1:0] base,
                       input int delay, input int drop, input bit rep);
    q_act[i] = 1; q_len[i] = len; q_we[i] = w; q_base[i] = base; q_delay[i] = delay;
    q_drop[i] = drop; q_repeat[i] = rep; q_idx[i] = 0;
  endtask

  task automatic clear_obs();
    cyc = -1; seg_owner.delete(); seg_start.delete(); seg_len.delete();
    prev_dut_x = 0; rv1_cnt = 0; seen_wr = 0; first_wr_addr = '0;
    for (int i = 0; i < 64; i++) busy_hist[i] = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, bus.gnt, 0);
    chk({tag, "_rvalid"}, bus.rvalid, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_owner"}, bus.owner, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_re"}, bus.mem_re, 0);
    chk({tag, "_wr_addr"}, bus.mem_wr_addr, 0);
    chk({tag, "_rd_addr"}, bus.mem_rd_addr, 0);
    chk({tag, "_wr_data"}, bus.mem_wr_data, 0);
  endtask

  // Called at posedge+1; leaves the DUT out of reset at posedge+1.
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    clear_req();
    drive_inputs();
    bus.mem_rd_data = '0;
    #1;
    chk_all_zero(tag);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero({tag, "_hold"});
    rst_n = 1'b1;
    m_lock = -1; m_arb = 0; m_ptr = 0; m_cnt = 0; m_owner = 0; m_tag = -1; m_rdata = '0;
    clear_obs();
  endtask

  task automatic step();
    logic [N-1:0]  eg, erv;
    logic          ex, ewe, ere;
    logic [AW-1:0] ewa, era;
    logic [DW-1:0] ewd, nxt_rd;
    int            o, k;
    bit            dut_x, found;
    @(negedge clk);
    cyc++;
    o = m_lock;
    eg = '0; ex = 0; ewe = 0; ere = 0; ewa = '0; era = '0; ewd = '0;
    if (o >= 0) begin
      eg[o] = bus.req[o];
      ex    = bus.req[o];
      ewe   = ex && bus.we[o];
      ere   = ex && !bus.we[o];
      if (ewe) begin ewa = bus.addr[o]; ewd = bus.wdata[o]; end
      if (ere) era = bus.addr[o];
    end
    erv = '0;
    if (m_tag >= 0) erv[m_tag] = 1'b1;

    chk("gnt", bus.gnt, eg);
    chk("rvalid", bus.rvalid, erv);
    if (m_tag >= 0) chk("rdata", bus.rdata, m_rdata);
    chk("busy", bus.busy, (m_arb || m_lock >= 0));
    chk("owner", bus.owner, m_owner);
    chk("mem_we", bus.mem_we, ewe);
    chk("mem_re", bus.mem_re, ere);
    chk("mem_wr_addr", bus.mem_wr_addr, ewa);
    chk("mem_wr_data", bus.mem_wr_data, ewd);
    chk("mem_rd_addr", bus.mem_rd_addr, era);

    // DUT observations
    dut_x = |(bus.gnt & bus.req);
    if (dut_x) begin
      k = 0;
      for (int i = 0; i < N; i++) if (bus.gnt[i]) k = i;
      if (!prev_dut_x) begin
        seg_owner.push_back(k); seg_start.push_back(cyc); seg_len.push_back(0);
      end
      seg_len[seg_len.size()-1]++;
    end
    prev_dut_x = dut_x;
    if (cyc < 64) busy_hist[cyc] = bus.busy;
    if (bus.rvalid == 3'b010) rv1_cnt++;
    if (bus.mem_we && !seen_wr) begin seen_wr = 1; first_wr_addr = bus.mem_wr_addr; end

    // Model advance
    nxt_rd = DW'($urandom);
    m_tag = -1;
    if (ere) begin m_tag = o; m_rdata = memval(era); nxt_rd = memval(era); end
    if (m_lock >= 0) begin
      if (ex) m_cnt++;
      if (!ex || bus.last[o] || m_cnt == MAXB) begin
        m_lock = -1;
        m_ptr = (o + 1) % N;
      end
    end else if (m_arb) begin
      m_arb = 0;
      found = 0;
      for (int d = 0; d < N; d++) begin
        k = (m_ptr + d) % N;
        if (!found && bus.req[k]) begin
          found = 1; m_lock = k; m_owner = k; m_cnt = 0;
        end
      end
    end else if (|bus.req) begin
      m_arb = 1;
    end
    last_exp_re = ere;

    // Requester advance on transfers
    for (int i = 0; i < N; i++) begin
      if (bus.req[i] && eg[i]) begin
        q_idx[i]++;
        if (q_idx[i] >= q_len[i]) begin
          if (q_repeat[i]) q_idx[i] = 0;
          else begin q_act[i] = 0; q_gap[i] = rand_mode ? int'($urandom_range(0, 4)) : 0; end
        end else if (q_idx[i] == q_drop[i]) begin
          q_act[i] = 0; q_gap[i] = rand_mode ? int'($urandom_range(0, 4)) : 0;
        end
      end
    end

    @(posedge clk);
    #1;
    bus.mem_rd_data = nxt_rd;
    for (int i = 0; i < N; i++) begin
      if (q_act[i] && q_delay[i] > 0) q_delay[i]--;
      if (rand_mode && !q_act[i]) begin
        if (q_gap[i] > 0) q_gap[i]--;
        else if ($urandom_range(0, 2) == 0) begin
          int len;
          len = int'($urandom_range(1, 12));
          start(i, len, 1'($urandom_range(0, 1)), $urandom, 0,
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : -1, 0);
        end
      end
    end
    drive_inputs();
  endtask

  initial begin
    clear_req();
    drive_inputs();
    bus.mem_rd_data = '0;
    @(posedge clk);
    #1;

    // 1: single write burst of 4 at 0x100
    apply_reset("reset");
    start(0, 4, 1, 32'h100, 0, -1, 0);
    drive_inputs();
    repeat (10) step();
    chk("t1_nseg", seg_owner.size(), 1);
    chk("t1_first_gnt", qget(seg_start, 0), 2);
    chk("t1_len", qget(seg_len, 0), 4);
    chk("t1_first_addr", first_wr_addr, 32'h100);
    chk("t1_busy_c5", busy_hist[5], 1);
    chk("t1_busy_c6", busy_hist[6], 0);

    // 2: round robin between two continuous requesters, 2-word bursts
    apply_reset("rst2");
    start(0, 2, 1, 32'h200, 0, -1, 1);
    start(1, 2, 1, 32'h300, 0, -1, 1);
    drive_inputs();
    repeat (17) step();
    chk("t2_o0", qget(seg_owner, 0), 0);
    chk("t2_o1", qget(seg_owner, 1), 1);
    chk("t2_o2", qget(seg_owner, 2), 0);
    chk("t2_o3", qget(seg_owner, 3), 1);
    chk("t2_s1", qget(seg_start, 1), 6);
    chk("t2_s3", qget(seg_start, 3), 14);

    // 3: read burst cut by MAX_BURST, requester 0 waiting
    apply_reset("rst3");
    start(1, 20, 0, 32'h4000, 0, -1, 0);
    start(0, 2, 1, 32'h500, 2, -1, 0);
    drive_inputs();
    repeat (15) step();
    chk("t3_len0", qget(seg_len, 0), 8);
    chk("t3_owner1", qget(seg_owner, 1), 0);
    chk("t3_start1", qget(seg_start, 1), 12);
    chk("t3_rv1_cnt", rv1_cnt, 8);

    // 4: last coincides with the limit
    apply_reset("rst4");
    start(1, 8, 0, 32'h6000, 0, -1, 0);
    start(0, 1, 1, 32'h700, 2, -1, 0);
    start(2, 1, 1, 32'h800, 2, -1, 0);
    drive_inputs();
    repeat (17) step();
    chk("t4_len0", qget(seg_len, 0), 8);
    chk("t4_owner1", qget(seg_owner, 1), 2);
    chk("t4_start1", qget(seg_start, 1), 12);
    chk("t4_owner2", qget(seg_owner, 2), 0);

    // 5: requester abandons after 2 of 5 words
    apply_reset("rst5");
    start(0, 5, 1, 32'h900, 0, 2, 0);
    start(2, 8, 1, 32'hA00, 3, -1, 0);
    drive_inputs();
    repeat (17) step();
    chk("t5_len0", qget(seg_len, 0), 2);
    chk("t5_busy_c5", busy_hist[5], 0);
    chk("t5_owner1", qget(seg_owner, 1), 2);
    chk("t5_start1", qget(seg_start, 1), 7);
    chk("t5_len1", qget(seg_len, 1), 8);

    // 6: reset asserted while a read is returning
    apply_reset("rst6");
    start(1, 4, 0, 32'hB000, 0, -1, 0);
    drive_inputs();
    last_exp_re = 0;
    for (int n = 0; n < 8 && !last_exp_re; n++) step();
    chk("t6_read_seen", last_exp_re, 1);
    apply_reset("t6_mid");
    start(1, 2, 0, 32'hC000, 0, -1, 0);
    start(2, 2, 0, 32'hD000, 0, -1, 0);
    drive_inputs();
    repeat (8) step();
    chk("t6_owner0", qget(seg_owner, 0), 1);
    chk("t6_start0", qget(seg_start, 0), 2);

    // Randomized traffic
    apply_reset("rst7");
    rand_mode = 1;
    repeat (4000) step();
    rand_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
